delay_timer_arbiter: RTL and testbench

Shares one down-counting delay timer between `REQ_COUNT` requesters. Each requester asks for a delay of `delay_i` ticks; the block grants the timer round-robin, loads the counter, counts it down to zero and returns a one-cycle `done_o` pulse to the owner. It sits between the control FSMs that need wait states (bus turnaround, debounce, retry back-off) and the single shared down counter in the utility memory library.

---
 rtl/delay_timer_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_delay_timer_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_timer_arbiter                                        |
// | Description : Round-robin arbiter that shares one down-counting delay    |
// |               timer between REQ_COUNT requesters. The owner's delay is   |
// |               loaded, counted down to zero, and a one-cycle done pulse   |
// |               is returned to that owner.                                 |
// | Options     : DELAY_TIMER_ARB_PRESCALE_EN - adds prescale_i and a        |
// |               PRESCALE_WIDTH prescaler (ticks-per-decrement minus one).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delay_timer_arbiter #(
  parameter int WORD_WIDTH     = 8,
  parameter int REQ_COUNT      = 4,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [REQ_COUNT-1:0]            req_i,
  input  logic [REQ_COUNT*WORD_WIDTH-1:0] delay_i,
`ifdef DELAY_TIMER_ARB_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0]       prescale_i,
`endif
  output logic [REQ_COUNT-1:0]            grant_o,
  output logic [REQ_COUNT-1:0]            done_o,
  output logic                            busy_o,
  output logic [WORD_WIDTH-1:0]           remaining_o
);

  localparam int IDX_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  localparam logic [IDX_W-1:0] c_last_idx      = IDX_W'(REQ_COUNT - 1);
  localparam logic [IDX_W:0]   c_req_count_ext = (IDX_W + 1)'(REQ_COUNT);
  localparam logic [REQ_COUNT-1:0] c_onehot0   = REQ_COUNT'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Configurations that cannot work leave this marker block in the hierarchy.
  if (WORD_WIDTH < 2 || REQ_COUNT < 2 || PRESCALE_WIDTH < 1) begin : g_illegal_params
  end

  state_t                r_state;
  state_t                w_state_nxt;

  logic [IDX_W-1:0]      r_ptr;        // round-robin scan start
  logic [IDX_W-1:0]      r_win;        // current / last owner index
  logic [WORD_WIDTH-1:0] r_cnt;        // shared down counter

  logic [WORD_WIDTH-1:0] w_delay [REQ_COUNT];
  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;
  logic [IDX_W:0]        w_sum;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_win_next;
  logic [REQ_COUNT-1:0]  w_win_onehot;
  logic                  w_owner_req;

  logic                  w_load;       // LOAD cycle: sample delay (and prescale)
  logic                  w_count_run;  // COUNT cycle with a non-zero counter
  logic                  w_tick;       // counter decrements this cycle
  logic                  w_ptr_adv;    // ownership ends (done or abort)
  logic                  w_grant_en;
  logic                  w_done_en;

  // Split the flat delay bus into one word per requester.
  for (genvar k = 0; k < REQ_COUNT; k++) begin : g_delay_unpack
    assign w_delay[k] = delay_i[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign w_owner_req  = req_i[r_win];
  assign w_win_onehot = c_onehot0 << r_win;
  assign w_win_next   = (r_win == c_last_idx) ? '0 : r_win + IDX_W'(1);

  // Pick the first requester at or after the pointer, wrapping at REQ_COUNT.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W + 1)'(i);
      if (w_sum >= c_req_count_ext) begin
        w_sum = w_sum - c_req_count_ext;
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and control decode; an owner dropping its request aborts.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_count_run = 1'b0;
    w_ptr_adv   = 1'b0;
    w_grant_en  = 1'b0;
    w_done_en   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_grant_en = 1'b1;
        w_load     = 1'b1;
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_ptr_adv   = 1'b1;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        w_grant_en = 1'b1;
        if (!w_owner_req) begin
          w_state_nxt = ST_IDLE;
          w_ptr_adv   = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_count_run = 1'b1;
        end
      end
      ST_DONE: begin
        w_grant_en  = 1'b1;
        w_done_en   = 1'b1;
        w_ptr_adv   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef DELAY_TIMER_ARB_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] r_pre;

  assign w_tick = w_count_run && (r_pre == '0);

  // Prescaler: reload on LOAD and on every tick, otherwise count down.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_pre <= '0;
    end else if (w_load) begin
      r_pre <= prescale_i;
    end else if (w_count_run) begin
      if (r_pre == '0) begin
        r_pre <= prescale_i;
      end else begin
        r_pre <= r_pre - PRESCALE_WIDTH'(1);
      end
    end
  end
`else
  assign w_tick = w_count_run;
`endif

  // Shared counter: load the owner's delay, then decrement on ticks.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= w_delay[r_win];
    end else if (w_tick) begin
      r_cnt <= r_cnt - WORD_WIDTH'(1);
    end
  end

  // Arbitration bookkeeping: latch the winner, move the pointer past it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_win <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == ST_IDLE && w_found) begin
        r_win <= w_pick;
      end
      if (w_ptr_adv) begin
        r_ptr <= w_win_next;
      end
    end
  end

  assign grant_o     = w_grant_en ? w_win_onehot : '0;
  assign done_o      = w_done_en  ? w_win_onehot : '0;
  assign busy_o      = (r_state != ST_IDLE);
  assign remaining_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_delay_timer_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_delay_timer_arbiter                                     |
// | Description : Directed self-checking bench for delay_timer_arbiter.      |
// |               Prescaler case runs only with DELAY_TIMER_ARB_PRESCALE_EN. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_delay_timer_arbiter;

  localparam int WORD_WIDTH     = 8;
  localparam int REQ_COUNT      = 4;
  localparam int PRESCALE_WIDTH = 4;

  logic                            clk_i;
  logic                            arst_i;
  logic [REQ_COUNT-1:0]            req_i;
  logic [REQ_COUNT*WORD_WIDTH-1:0] delay_i;
  logic [PRESCALE_WIDTH-1:0]       prescale_i;
  logic [REQ_COUNT-1:0]            grant_o;
  logic [REQ_COUNT-1:0]            done_o;
  logic                            busy_o;
  logic [WORD_WIDTH-1:0]           remaining_o;

  int n_checks;
  int n_fail;

  delay_timer_arbiter #(
    .WORD_WIDTH     (WORD_WIDTH),
    .REQ_COUNT      (REQ_COUNT),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .req_i       (req_i),
    .delay_i     (delay_i),
`ifdef DELAY_TIMER_ARB_PRESCALE_EN
    .prescale_i  (prescale_i),
`endif
    .grant_o     (grant_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .remaining_o (remaining_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_delay(input int k, input logic [WORD_WIDTH-1:0] d);
    delay_i[k*WORD_WIDTH +: WORD_WIDTH] = d;
  endtask

  logic [REQ_COUNT-1:0] exp_g;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    arst_i     = 1'b1;
    req_i      = '0;
    delay_i    = '0;
    prescale_i = '0;
    step();
    step();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_rem", 32'(remaining_o), 32'h0);
    arst_i = 1'b0;
    step();
    chk("idle_busy", 32'(busy_o), 32'h0);

    // Single request, delay 5: done 7 cycles after LOAD.
    set_delay(0, 8'd5);
    req_i = 4'b0001;
    step();                                   // LOAD (t)
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_busy", 32'(busy_o), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      step();                                 // t+1 .. t+6
      chk("t1_rem", 32'(remaining_o), 32'(6 - k));
      chk("t1_nodone", 32'(done_o), 32'h0);
    end
    step();                                   // t+7
    chk("t1_done", 32'(done_o), 32'h1);
    chk("t1_grant_done", 32'(grant_o), 32'h1);
    req_i = 4'b0000;
    step();
    chk("t1_idle_busy", 32'(busy_o), 32'h0);
    chk("t1_idle_done", 32'(done_o), 32'h0);
    chk("t1_idle_grant", 32'(grant_o), 32'h0);

    // Zero delay on requester 2 (pointer is 1).
    set_delay(2, 8'd0);
    req_i = 4'b0100;
    step();                                   // LOAD
    chk("t2_grant", 32'(grant_o), 32'h4);
    step();                                   // COUNT
    chk("t2_rem", 32'(remaining_o), 32'h0);
    chk("t2_nodone", 32'(done_o), 32'h0);
    step();                                   // DONE at t+2
    chk("t2_done", 32'(done_o), 32'h4);
    req_i = 4'b0000;
    step();
    chk("t2_idle", 32'(busy_o), 32'h0);

    // Reset to put the pointer back at 0, then round-robin with all held.
    arst_i = 1'b1;
    step();
    arst_i = 1'b0;
    for (int k = 0; k < REQ_COUNT; k++) set_delay(k, 8'd1);
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'(1 << (g % 4));
      step();                                 // LOAD
      chk("rr_grant", 32'(grant_o), 32'(exp_g));
      step();
      chk("rr_rem1", 32'(remaining_o), 32'h1);
      step();
      chk("rr_rem0", 32'(remaining_o), 32'h0);
      chk("rr_nodone", 32'(done_o), 32'h0);
      step();                                 // DONE
      chk("rr_done", 32'(done_o), 32'(exp_g));
      if (g == 4) req_i = 4'b0000;
      step();                                 // IDLE
      chk("rr_idle", 32'(busy_o), 32'h0);
      chk("rr_idle_grant", 32'(grant_o), 32'h0);
    end

    // Abort: pointer is 1; requester 1 with delay 10 drops 3 cycles after LOAD.
    set_delay(1, 8'd10);
    set_delay(3, 8'd2);
    req_i = 4'b0010;
    step();                                   // LOAD
    chk("ab_grant", 32'(grant_o), 32'h2);
    step();
    step();
    step();                                   // t+3
    chk("ab_rem", 32'(remaining_o), 32'd8);
    req_i = 4'b1001;                          // owner drops, 0 and 3 pending
    step();                                   // IDLE
    chk("ab_busy", 32'(busy_o), 32'h0);
    chk("ab_nodone", 32'(done_o), 32'h0);
    req_i = 4'b1011;
    step();                                   // LOAD for requester 3
    chk("ab_next_grant", 32'(grant_o), 32'h8);
    req_i = 4'b0000;                          // abort from LOAD
    step();
    chk("ab2_busy", 32'(busy_o), 32'h0);
    chk("ab2_nodone", 32'(done_o), 32'h0);

`ifdef DELAY_TIMER_ARB_PRESCALE_EN
    // Prescaler: pointer is 0; delay 3, prescale 2 -> done at LOAD+11.
    set_delay(0, 8'd3);
    prescale_i = 4'd2;
    req_i = 4'b0001;
    step();                                   // LOAD
    chk("ps_grant", 32'(grant_o), 32'h1);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("ps_rem", 32'(remaining_o), 32'(3 - ((k - 1) / 3)));
      chk("ps_nodone", 32'(done_o), 32'h0);
    end
    step();
    chk("ps_done", 32'(done_o), 32'h1);
    req_i = 4'b0000;
    prescale_i = 4'd0;
    step();
    chk("ps_idle", 32'(busy_o), 32'h0);
`endif

    // Async reset mid-count.
    set_delay(1, 8'd8);
    req_i = 4'b0010;
    step();                                   // LOAD
    chk("ar_grant", 32'(grant_o), 32'h2);
    for (int k = 1; k <= 5; k++) step();      // t+5: remaining 4
    chk("ar_rem4", 32'(remaining_o), 32'd4);
    arst_i = 1'b1;
    #1;
    chk("ar_grant0", 32'(grant_o), 32'h0);
    chk("ar_busy0", 32'(busy_o), 32'h0);
    chk("ar_rem0", 32'(remaining_o), 32'h0);
    chk("ar_done0", 32'(done_o), 32'h0);
    step();
    arst_i = 1'b0;
    step();                                   // LOAD after scan from 0
    chk("ar_regrant", 32'(grant_o), 32'h2);
    req_i = 4'b0000;
    step();
    chk("ar_end_busy", 32'(busy_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
